mcpu_ctrl: RTL and testbench
============================

# mcpu_ctrl

Multi-cycle control unit for the single-port MIPS-subset CPU built around the PC register and the synchronous instruction ROM (`ROM_B`, 64×32, one-cycle read latency).
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Drives all datapath enables and mux selects from a Moore FSM.
- Keeps a retired-instruction counter and flags illegal encodings.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`, in, 1, system clock; all state changes on the rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `opcode`, in, 6, IR[31:26] from the datapath IR.
- `funct`, in, 6, IR[5:0].
- `zero`, in, 1, ALU zero flag, combinational from the datapath.
- `pc_write`, out, 1, load PC this edge.
- `ir_write`, out, 1, load IR from ROM `douta` this edge.
- `pc_src`, out, 2, PC next-value select: 00 = ALU result, 01 = ALUOut register (branch target), 10 = jump target {PC[31:28], IR[25:0], 2'b00}.
- `alu_src_a`, out, 1, ALU A select: 0 = PC, 1 = rs register.
- `alu_src_b`, out, 2, ALU B select: 00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `alu_op`, out, 3, ALU function: 000 = add, 001 = sub, 010 = and, 011 = or, 100 = slt.
- `reg_write`, out, 1, register file write enable.
- `reg_dst`, out, 1, write-address select: 0 = rt, 1 = rd.
- `mem_to_reg`, out, 1, write-data select: 0 = ALUOut, 1 = MDR.
- `mem_write`, out, 1, data RAM write enable.
- `illegal`, out, 1, one-cycle pulse on an unsupported opcode/funct.
- `state`, out, 4, current FSM state encoding, for debug.
- `retired`, out, CNT_W, count of completed legal instructions.

## Operation
- State encodings:
  - IF0 = 0, IF1 = 1, ID = 2
  - EXR = 3, WBR = 4
  - EXI = 5, WBI = 6
  - ADR = 7, MRD = 8, WBM = 9, MWR = 10
  - BR = 11, JMP = 12
  - Codes 13–15 unused; if reached, the next state is IF0.
- IF0: PC drives the ROM address. All enables are 0. Next state is IF1.
- IF1: `ir_write`=1, `pc_write`=1, `pc_src`=00, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=add (PC ← PC+4). Next state is ID.
- ID: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=add (precompute the branch target into ALUOut). Decode:
  - `opcode` 0x00, funct 0x20/0x22/0x24/0x25/0x2A → EXR
  - `opcode` 0x08 (addi) → EXI
  - `opcode` 0x23 (lw) or 0x2B (sw) → ADR
  - `opcode` 0x04 (beq) → BR
  - `opcode` 0x02 (j) → JMP
  - Any other encoding → IF0 with `illegal`=1 for the ID cycle; `retired` unchanged.
- EXR: `alu_src_a`=1, `alu_src_b`=00, `alu_op` from funct (0x20 → add, 0x22 → sub, 0x24 → and, 0x25 → or, 0x2A → slt). Next state is WBR.
- WBR: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next state is IF0.
- EXI: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=add. Next state is WBI.
- WBI: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next state is IF0.
- ADR: same ALU selects as EXI. Next state is MRD (lw) or MWR (sw).
- MRD: all enables 0 (data RAM read latency). Next state is WBM.
- WBM: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Next state is IF0.
- MWR: `mem_write`=1. Next state is IF0.
- BR: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=sub, `pc_src`=01, `pc_write`=`zero` (combinational). Next state is IF0.
- JMP: `pc_src`=10, `pc_write`=1. Next state is IF0.
- Default output values (any signal not listed for a state): all enables 0, selects 0, `alu_op`=000.
- `retired` increments by 1 on the edge leaving WBR, WBI, WBM, MWR, BR or JMP. It wraps from 2^CNT_W−1 to 0.

## Timing
- Reset: `rst` high at an edge forces state=IF0 and `retired`=0, regardless of the current state (including mid-instruction). In IF0 every enable output is 0 and `illegal`=0.
- The first `ir_write` occurs in the second cycle after `rst` deasserts.
- Cycles per instruction: R-type 5, addi 5, lw 6, sw 5, beq 4, j 4, illegal 3.
- All outputs are Moore functions of `state`, with these exceptions:
  - `alu_op` in EXR, which depends on `funct`.
  - `pc_write` in BR, which depends on `zero`.
  - `illegal` in ID, which depends on `opcode`/`funct`.
- IR is stable from the end of IF1 until the next IF1. Decode uses the registered IR only.

## Test plan
- Reset, then IR=0x00221820 (add $3,$1,$2): state 0→1→2→3→4→0; `reg_write`=`reg_dst`=1 only in state 4; `alu_op`=000 in EXR; `retired`=1.
- IR=0x8C220004 (lw): 6 cycles; `mem_to_reg`=1 and `reg_write`=1 only in WBM; `alu_src_b`=10 in ADR. Then IR=0xAC220004 (sw): `mem_write`=1 for exactly one cycle, in MWR.
- IR=0x10220003 (beq) with `zero`=1 → `pc_write`=1 and `pc_src`=01 in BR. Same instruction with `zero`=0 → `pc_write`=0. Both cases take 4 cycles.
- IR=0x08000004 (j) → `pc_write`=1, `pc_src`=10 in JMP. IR=0x20210005 (addi) → WBI with `reg_dst`=0.
- IR=0xFC000000 and IR=0x00000021 (unsupported funct) → `illegal` pulses for 1 cycle in ID; next state is IF0; `retired` unchanged; no `reg_write` or `mem_write` ever asserted.
- Assert `rst` during MRD → next state is IF0, `retired`=0, `reg_write` never asserted. Separately, preload `retired`=0xFFFFFFFF, retire one instruction → `retired` reads 0.

Source files
------------

// File: rtl/mcpu_ctrl.sv
// Multi-cycle Moore control FSM for the single-port MIPS-subset CPU.
// Sequences fetch/decode/execute/memory/write-back and counts retirements.
module mcpu_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_write,
    output logic             ir_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             mem_write,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] S_IF0 = 4'd0;
    localparam logic [3:0] S_IF1 = 4'd1;
    localparam logic [3:0] S_ID  = 4'd2;
    localparam logic [3:0] S_EXR = 4'd3;
    localparam logic [3:0] S_WBR = 4'd4;
    localparam logic [3:0] S_EXI = 4'd5;
    localparam logic [3:0] S_WBI = 4'd6;
    localparam logic [3:0] S_ADR = 4'd7;
    localparam logic [3:0] S_MRD = 4'd8;
    localparam logic [3:0] S_WBM = 4'd9;
    localparam logic [3:0] S_MWR = 4'd10;
    localparam logic [3:0] S_BR  = 4'd11;
    localparam logic [3:0] S_JMP = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic [3:0]       id_next;
    logic             id_legal;
    logic             funct_ok;
    logic [2:0]       funct_op;
    logic             retire;
    logic [CNT_W-1:0] retired_q;

    always_comb begin
        funct_ok = 1'b1;
        funct_op = ALU_ADD;
        case (funct)
            FN_ADD:  funct_op = ALU_ADD;
            FN_SUB:  funct_op = ALU_SUB;
            FN_AND:  funct_op = ALU_AND;
            FN_OR:   funct_op = ALU_OR;
            FN_SLT:  funct_op = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    // Decode reads only the registered IR fields.
    always_comb begin
        id_next  = S_IF0;
        id_legal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                if (funct_ok) id_next = S_EXR;
                else          id_legal = 1'b0;
            end
            OP_ADDI: id_next = S_EXI;
            OP_LW,
            OP_SW:   id_next = S_ADR;
            OP_BEQ:  id_next = S_BR;
            OP_J:    id_next = S_JMP;
            default: id_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_IF0;
        case (state_q)
            S_IF0: state_d = S_IF1;
            S_IF1: state_d = S_ID;
            S_ID:  state_d = id_next;
            S_EXR: state_d = S_WBR;
            S_EXI: state_d = S_WBI;
            S_ADR: state_d = (opcode == OP_LW) ? S_MRD : S_MWR;
            S_MRD: state_d = S_WBM;
            default: state_d = S_IF0;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_WBR, S_WBI, S_WBM,
            S_MWR, S_BR, S_JMP: retire = 1'b1;
            default:            retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IF0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + CNT_ONE;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_IF1: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
            end
            // Branch target lands in ALUOut while decoding.
            S_ID: begin
                alu_src_b = 2'b11;
                illegal   = ~id_legal;
            end
            S_EXR: begin
                alu_src_a = 1'b1;
                alu_op    = funct_op;
            end
            S_WBR: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_EXI, S_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_WBI: reg_write = 1'b1;
            S_WBM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MWR: mem_write = 1'b1;
            S_BR: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'b01;
                pc_write  = zero;
            end
            S_JMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Self-checking bench for mcpu_ctrl: bench acts as IR/ROM datapath and
// compares against an instruction-level model of state flow and strobes.
module tb_mcpu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode, funct;
    logic        zero;
    logic        pc_write, ir_write, alu_src_a, reg_write;
    logic        reg_dst, mem_to_reg, mem_write, illegal;
    logic [1:0]  pc_src, alu_src_b;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic [31:0] retired;

    logic        w_pc_write, w_ir_write, w_alu_src_a, w_reg_write;
    logic        w_reg_dst, w_mem_to_reg, w_mem_write, w_illegal;
    logic [1:0]  w_pc_src, w_alu_src_b;
    logic [2:0]  w_alu_op;
    logic [3:0]  w_state;
    logic [2:0]  w_retired;

    logic [31:0] ir = 32'h0;
    logic [31:0] rom_word = 32'h0;
    int          checks = 0;
    int          errors = 0;
    longint      exp_ret = 0;

    mcpu_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(pc_write), .ir_write(ir_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .mem_write(mem_write), .illegal(illegal), .state(state),
        .retired(retired)
    );

    // Narrow-counter twin runs in lockstep to exercise counter wrap.
    mcpu_ctrl #(.CNT_W(3)) u_w (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(w_pc_write), .ir_write(w_ir_write), .pc_src(w_pc_src),
        .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
        .alu_op(w_alu_op), .reg_write(w_reg_write), .reg_dst(w_reg_dst),
        .mem_to_reg(w_mem_to_reg), .mem_write(w_mem_write),
        .illegal(w_illegal), .state(w_state), .retired(w_retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ir_write) ir <= rom_word;
    assign opcode = ir[31:26];
    assign funct  = ir[5:0];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit rfn_ok(input logic [5:0] f);
        return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    endfunction

    function automatic logic [2:0] alu_for(input logic [5:0] f);
        case (f)
            6'h22:   return 3'd1;
            6'h24:   return 3'd2;
            6'h25:   return 3'd3;
            6'h2A:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] b;
        logic [5:0]  f;
        logic [5:0]  o;
        logic [5:0]  fns [5];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        b = $urandom;
        case ($urandom_range(0, 7))
            0: return {6'h00, b[25:6], fns[$urandom_range(0, 4)]};
            1: begin
                do f = 6'($urandom_range(0, 63)); while (rfn_ok(f));
                return {6'h00, b[25:6], f};
            end
            2: return {6'h08, b[25:0]};
            3: return {6'h23, b[25:0]};
            4: return {6'h2B, b[25:0]};
            5: return {6'h04, b[25:0]};
            6: return {6'h02, b[25:0]};
            default: begin
                do o = 6'($urandom_range(0, 63));
                while (o inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B});
                return {o, b[25:0]};
            end
        endcase
    endfunction

    // zmode: 0/1 force zero, 2 randomize zero every cycle.
    task automatic run_instr(input logic [31:0] w, input int zmode);
        logic [5:0] op;
        logic [5:0] fn;
        int seq[$];
        int st;
        int rw_exp, mw_exp, ill_exp;
        int nrw, nmw, nir, nill;
        op = w[31:26];
        fn = w[5:0];
        seq = '{0, 1, 2};
        rw_exp = 0; mw_exp = 0; ill_exp = 0;
        nrw = 0; nmw = 0; nir = 0; nill = 0;
        if (op == 6'h00 && rfn_ok(fn)) begin
            seq.push_back(3); seq.push_back(4); rw_exp = 1;
        end else if (op == 6'h08) begin
            seq.push_back(5); seq.push_back(6); rw_exp = 1;
        end else if (op == 6'h23) begin
            seq.push_back(7); seq.push_back(8); seq.push_back(9); rw_exp = 1;
        end else if (op == 6'h2B) begin
            seq.push_back(7); seq.push_back(10); mw_exp = 1;
        end else if (op == 6'h04) begin
            seq.push_back(11);
        end else if (op == 6'h02) begin
            seq.push_back(12);
        end else begin
            ill_exp = 1;
        end
        rom_word = w;
        foreach (seq[k]) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
            #1;
            st = seq[k];
            chk("state", 32'(state), 32'(st));
            nrw  += int'(reg_write);
            nmw  += int'(mem_write);
            nir  += int'(ir_write);
            nill += int'(illegal);
            case (st)
                0: chk("if0_en", {pc_write, ir_write, reg_write, mem_write,
                                  illegal}, 0);
                1: chk("if1", {ir_write, pc_write, pc_src, alu_src_a,
                               alu_src_b, alu_op}, {1'b1, 1'b1, 8'b00_0_01_000});
                2: chk("id", {alu_src_a, alu_src_b, alu_op, illegal},
                       {6'b0_11_000, 1'(ill_exp)});
                3: chk("exr", {alu_src_a, alu_src_b, alu_op},
                       {3'b1_00, alu_for(fn)});
                4: chk("wbr", {reg_write, reg_dst, mem_to_reg}, 3'b110);
                5: chk("exi", {alu_src_a, alu_src_b, alu_op}, 6'b1_10_000);
                6: chk("wbi", {reg_write, reg_dst, mem_to_reg}, 3'b100);
                7: chk("adr", {alu_src_a, alu_src_b, alu_op}, 6'b1_10_000);
                8: chk("mrd_en", {pc_write, reg_write, mem_write}, 0);
                9: chk("wbm", {reg_write, reg_dst, mem_to_reg}, 3'b101);
                10: chk("mwr", {mem_write, reg_write, pc_write}, 3'b100);
                11: chk("br", {pc_write, pc_src, alu_src_a, alu_src_b, alu_op},
                        {zero, 8'b01_1_00_001});
                12: chk("jmp", {pc_write, pc_src}, 3'b110);
                default: ;
            endcase
            @(posedge clk);
            #1;
        end
        if (ill_exp == 0) exp_ret++;
        chk("end_state", 32'(state), 0);
        chk("retired", retired, 32'(exp_ret));
        chk("retired_wrap3", 32'(w_retired), 32'(exp_ret % 8));
        chk("n_reg_write", nrw, rw_exp);
        chk("n_mem_write", nmw, mw_exp);
        chk("n_ir_write", nir, 1);
        chk("n_illegal", nill, ill_exp);
    endtask

    initial begin
        rst  = 1'b1;
        zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_retired", retired, 0);
        chk("rst_retired_w", 32'(w_retired), 0);
        chk("rst_en", {pc_write, ir_write, reg_write, mem_write, illegal}, 0);
        rst = 1'b0;

        run_instr(32'h00221820, 2);
        run_instr(32'h8C220004, 2);
        run_instr(32'hAC220004, 2);
        run_instr(32'h10220003, 1);
        run_instr(32'h10220003, 0);
        run_instr(32'h08000004, 2);
        run_instr(32'h20210005, 2);
        run_instr(32'hFC000000, 2);
        run_instr(32'h00000021, 2);
        run_instr(32'h00221822, 2);
        run_instr(32'h0022182A, 2);

        // Reset mid-load while in MRD.
        rom_word = 32'h8C220004;
        for (int k = 0; k < 4; k++) begin
            chk("mrd_pre_rw", 32'(reg_write), 0);
            @(posedge clk);
            #1;
        end
        chk("mrd_state", 32'(state), 8);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrd_rst_state", 32'(state), 0);
        chk("mrd_rst_retired", retired, 0);
        chk("mrd_rst_retired_w", 32'(w_retired), 0);
        chk("mrd_rst_rw", 32'(reg_write), 0);
        rst = 1'b0;
        exp_ret = 0;

        for (int i = 0; i < 80; i++) run_instr(rand_instr(), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
